// File: rtl/xc_malu_issue.sv
// xc_malu_issue: issue/writeback sequencer for the XCrypto multi-cycle ALU.
// Takes one decoded MALU instruction, holds the ALU inputs valid until the ALU
// reports ready, returns the 64-bit result as one or two 32-bit writeback beats,
// then spends one cycle flushing the ALU back to idle.
module xc_malu_issue #(
  parameter int MAX_CYCLES = 72  // RUN-state cycle limit, 2..127
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [2:0]  req_pw,
  input  logic        req_hi,
  input  logic        req_wide,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [31:0] req_rs3,
  input  logic [4:0]  req_rd,
  input  logic        kill,
  output logic [31:0] malu_rs1,
  output logic [31:0] malu_rs2,
  output logic [31:0] malu_rs3,
  output logic [13:0] malu_uop,
  output logic [4:0]  malu_pw,
  output logic        malu_valid,
  output logic        malu_flush,
  input  logic [63:0] malu_result,
  input  logic        malu_ready,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        err_illegal,
  output logic        err_timeout
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_WB_LO, S_WB_HI, S_FLUSH} state_t;

  state_t      state, state_nx;
  logic [6:0]  cnt;
  logic [63:0] res;
  logic [4:0]  rd_q;
  logic        hi_q, wide_q;
  logic [13:0] uop_d;
  logic [4:0]  pw_d;
  logic        op_illegal, accept, timeout_hit, timeout_fire;

  assign op_illegal   = (req_op > 4'd13);
  assign accept       = (state == S_IDLE) && req_valid;
  assign timeout_hit  = (cnt == 7'(MAX_CYCLES - 1));
  // kill and malu_ready both take precedence over the timeout
  assign timeout_fire = (state == S_RUN) && !kill && !malu_ready && timeout_hit;

  // Decode op code to one-hot uop and pack width to one-hot {2,4,8,16,32}
  always_comb begin
    uop_d = '0;
    for (int i = 0; i < 14; i++) uop_d[i] = (req_op == 4'(i));
    case (req_pw)
      3'd1:    pw_d = 5'b00010;
      3'd2:    pw_d = 5'b00100;
      3'd3:    pw_d = 5'b01000;
      3'd4:    pw_d = 5'b10000;
      default: pw_d = 5'b00001;
    endcase
  end

  // Next-state logic; kill beats any simultaneous ready
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (req_valid && !op_illegal) state_nx = S_RUN;
      S_RUN:   if (kill)              state_nx = S_FLUSH;
               else if (malu_ready)   state_nx = S_WB_LO;
               else if (timeout_hit)  state_nx = S_FLUSH;
      S_WB_LO: if (kill)              state_nx = S_FLUSH;
               else if (wb_ready)     state_nx = wide_q ? S_WB_HI : S_FLUSH;
      S_WB_HI: if (kill || wb_ready)  state_nx = S_FLUSH;
      S_FLUSH: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Instruction latch, cycle counter, result capture and error pulses
  always_ff @(posedge clock) begin
    if (!resetn) begin
      malu_rs1    <= '0;
      malu_rs2    <= '0;
      malu_rs3    <= '0;
      malu_uop    <= '0;
      malu_pw     <= '0;
      rd_q        <= '0;
      hi_q        <= 1'b0;
      wide_q      <= 1'b0;
      cnt         <= '0;
      res         <= '0;
      err_illegal <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      err_illegal <= accept && op_illegal;
      err_timeout <= timeout_fire;
      if (accept && !op_illegal) begin
        malu_rs1 <= req_rs1;
        malu_rs2 <= req_rs2;
        malu_rs3 <= req_rs3;
        malu_uop <= uop_d;
        malu_pw  <= pw_d;
        rd_q     <= req_rd;
        hi_q     <= req_hi;
        wide_q   <= req_wide;
        cnt      <= '0;
      end
      if (state == S_RUN) begin
        cnt <= cnt + 7'd1;
        if (malu_ready && !kill) res <= malu_result;
      end
    end
  end

  // Handshake outputs decode purely from state
  assign req_ready  = (state == S_IDLE);
  assign malu_valid = (state == S_RUN);
  assign malu_flush = (state == S_FLUSH);
  assign wb_valid   = (state == S_WB_LO) || (state == S_WB_HI);

  // Wide ops write the even/odd register pair; narrow ops pick a half via hi
  assign wb_rd   = wide_q ? {rd_q[4:1], (state == S_WB_HI)} : rd_q;
  assign wb_data = ((state == S_WB_HI) || (!wide_q && hi_q)) ? res[63:32] : res[31:0];

endmodule

// File: tb/tb_xc_malu_issue.sv
// Bench for xc_malu_issue: directed scenarios; expected writeback beats are
// queued by the stimulus and checked by an independent writeback monitor.
module tb_xc_malu_issue;

  logic        clock = 1'b0;
  logic        resetn;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [2:0]  req_pw;
  logic        req_hi, req_wide;
  logic [31:0] req_rs1, req_rs2, req_rs3;
  logic [4:0]  req_rd;
  logic        kill;
  logic [31:0] malu_rs1, malu_rs2, malu_rs3;
  logic [13:0] malu_uop;
  logic [4:0]  malu_pw;
  logic        malu_valid, malu_flush;
  logic [63:0] malu_result;
  logic        malu_ready;
  logic        wb_valid, wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_illegal, err_timeout;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed { logic [4:0] rd; logic [31:0] data; } beat_t;
  beat_t sb[$];

  always #5 clock = ~clock;

  xc_malu_issue #(.MAX_CYCLES(8)) dut (
    .clock(clock), .resetn(resetn),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_pw(req_pw),
    .req_hi(req_hi), .req_wide(req_wide), .req_rs1(req_rs1), .req_rs2(req_rs2),
    .req_rs3(req_rs3), .req_rd(req_rd), .kill(kill),
    .malu_rs1(malu_rs1), .malu_rs2(malu_rs2), .malu_rs3(malu_rs3),
    .malu_uop(malu_uop), .malu_pw(malu_pw), .malu_valid(malu_valid),
    .malu_flush(malu_flush), .malu_result(malu_result), .malu_ready(malu_ready),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .err_illegal(err_illegal), .err_timeout(err_timeout)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Writeback monitor: pops the scoreboard on each accepted beat and checks
  // that a stalled beat does not change while it waits
  logic  stalled = 1'b0;
  beat_t held;
  always @(negedge clock) begin
    if (wb_valid && stalled) begin
      chk("wb_stable_rd", 64'(wb_rd), 64'(held.rd));
      chk("wb_stable_data", 64'(wb_data), 64'(held.data));
    end
    if (wb_valid && wb_ready) begin
      if (sb.size() == 0) begin
        chk("wb_unexpected_beat", 64'(wb_valid), 64'd0);
      end else begin
        beat_t e;
        e = sb.pop_front();
        chk("wb_rd", 64'(wb_rd), 64'(e.rd));
        chk("wb_data", 64'(wb_data), 64'(e.data));
      end
    end
    stalled   = wb_valid && !wb_ready;
    held.rd   = wb_rd;
    held.data = wb_data;
  end

  task automatic step();
    @(posedge clock); #1;
  endtask

  // Present one request for a single cycle; afterwards we sit in cycle N+1
  task automatic issue(input logic [3:0] op, input logic [2:0] pw, input logic hi,
                       input logic wide, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] c, input logic [4:0] rd);
    chk("req_ready_before_issue", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_op = op; req_pw = pw; req_hi = hi; req_wide = wide;
    req_rs1 = a; req_rs2 = b; req_rs3 = c; req_rd = rd;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0; req_valid = 1'b0; req_op = '0; req_pw = '0; req_hi = 1'b0;
    req_wide = 1'b0; req_rs1 = '0; req_rs2 = '0; req_rs3 = '0; req_rd = '0;
    kill = 1'b0; malu_result = '0; malu_ready = 1'b0; wb_ready = 1'b0;
    step(); step();
    // Reset values
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_malu_valid", 64'(malu_valid), 64'd0);
    chk("rst_malu_flush", 64'(malu_flush), 64'd0);
    chk("rst_wb_valid", 64'(wb_valid), 64'd0);
    chk("rst_errs", 64'({err_illegal, err_timeout}), 64'd0);
    chk("rst_uop_pw", 64'({malu_uop, malu_pw}), 64'd0);
    resetn = 1'b1;
    step();

    // Single-beat mul, ready in the 4th RUN cycle
    issue(4'd4, 3'd0, 1'b0, 1'b0, 32'd3, 32'd5, 32'd0, 5'd7);
    chk("mul_malu_valid", 64'(malu_valid), 64'd1);
    chk("mul_uop", 64'(malu_uop), 64'h0010);
    chk("mul_pw", 64'(malu_pw), 64'b00001);
    chk("mul_rs", 64'({malu_rs1, malu_rs2}), {32'd3, 32'd5});
    chk("mul_req_ready", 64'(req_ready), 64'd0);
    step(); step(); step();
    chk("mul_run4_valid", 64'(malu_valid), 64'd1);
    chk("mul_run4_no_wb", 64'(wb_valid), 64'd0);
    malu_ready = 1'b1; malu_result = 64'h0000_0000_0000_000F; wb_ready = 1'b1;
    sb.push_back('{rd: 5'd7, data: 32'h0000_000F});
    step();
    malu_ready = 1'b0;
    chk("mul_wb_valid", 64'(wb_valid), 64'd1);
    chk("mul_wb_malu_valid", 64'(malu_valid), 64'd0);
    step();
    wb_ready = 1'b0;
    chk("mul_flush", 64'({malu_flush, malu_valid, wb_valid}), 64'b100);
    step();
    chk("mul_idle", 64'({req_ready, malu_flush}), 64'b10);

    // Wide madd with pw=8, minimum latency, 3 stall cycles per beat
    issue(4'd10, 3'd2, 1'b0, 1'b1, 32'h1, 32'h2, 32'h3, 5'd9);
    chk("madd_uop", 64'(malu_uop), 64'h0400);
    chk("madd_pw", 64'(malu_pw), 64'b00100);
    chk("madd_rs3", 64'(malu_rs3), 64'h3);
    malu_ready = 1'b1; malu_result = 64'h12345678_9ABCDEF0;
    sb.push_back('{rd: 5'd8, data: 32'h9ABCDEF0});
    sb.push_back('{rd: 5'd9, data: 32'h12345678});
    step();
    malu_ready = 1'b0; malu_result = '0;
    chk("madd_min_latency", 64'(wb_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      chk("madd_lo_rd", 64'(wb_rd), 64'd8);
      chk("madd_lo_data", 64'(wb_data), 64'h9ABCDEF0);
      step();
    end
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("madd_hi_rd", 64'(wb_rd), 64'd9);
      chk("madd_hi_data", 64'(wb_data), 64'h12345678);
      step();
    end
    wb_ready = 1'b1;
    step();
    wb_ready = 1'b0;
    chk("madd_flush", 64'({malu_flush, wb_valid}), 64'b10);
    step();
    chk("madd_idle", 64'(req_ready), 64'd1);

    // Kill in the 3rd RUN cycle together with malu_ready
    issue(4'd0, 3'd1, 1'b0, 1'b0, 32'hA, 32'hB, 32'hC, 5'd4);
    chk("kill_pw", 64'(malu_pw), 64'b00010);
    step(); step();
    kill = 1'b1; malu_ready = 1'b1; malu_result = 64'hDEAD_BEEF_DEAD_BEEF; wb_ready = 1'b1;
    step();
    kill = 1'b0; malu_ready = 1'b0;
    chk("kill_flush", 64'({malu_flush, wb_valid, malu_valid}), 64'b100);
    step();
    chk("kill_idle", 64'({req_ready, wb_valid}), 64'b10);
    // kill is ignored in IDLE: a request plus kill is still accepted
    kill = 1'b1;
    issue(4'd5, 3'd3, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd1);
    kill = 1'b0;
    chk("kill_idle_ignored", 64'(malu_valid), 64'd1);
    chk("mulu_pw", 64'(malu_pw), 64'b01000);
    kill = 1'b1;
    step();
    kill = 1'b0;
    chk("kill_run1_flush", 64'(malu_flush), 64'd1);
    step();

    // Timeout: no malu_ready for MAX_CYCLES=8 RUN cycles
    issue(4'd7, 3'd4, 1'b0, 1'b0, 32'h1, 32'h1, 32'h1, 5'd2);
    chk("to_pw", 64'(malu_pw), 64'b10000);
    for (int i = 0; i < 7; i++) begin
      chk("to_run_valid", 64'(malu_valid), 64'd1);
      chk("to_no_err_yet", 64'(err_timeout), 64'd0);
      step();
    end
    chk("to_run8_valid", 64'(malu_valid), 64'd1);
    step();
    chk("to_err_pulse", 64'({err_timeout, malu_flush, malu_valid}), 64'b110);
    step();
    chk("to_err_clear", 64'({err_timeout, req_ready, wb_valid}), 64'b010);
    wb_ready = 1'b0;

    // Illegal op
    issue(4'd15, 3'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd3);
    chk("ill_pulse", 64'({err_illegal, req_ready, malu_valid}), 64'b110);
    step();
    chk("ill_clear", 64'({err_illegal, req_ready, malu_valid}), 64'b010);

    // Reset during WB_HI of a wide mmul
    issue(4'd13, 3'd0, 1'b0, 1'b1, 32'h5, 32'h6, 32'h7, 5'd5);
    malu_ready = 1'b1; malu_result = 64'hAAAA_BBBB_CCCC_DDDD; wb_ready = 1'b1;
    sb.push_back('{rd: 5'd4, data: 32'hCCCC_DDDD});
    step();
    malu_ready = 1'b0;
    step();
    wb_ready = 1'b0;
    chk("rstwb_in_hi", 64'({wb_valid, wb_rd}), {1'b1, 5'd5});
    resetn = 1'b0;
    step();
    chk("rstwb_ready", 64'(req_ready), 64'd1);
    chk("rstwb_quiet", 64'({malu_valid, malu_flush, wb_valid}), 64'd0);
    chk("rstwb_wb_zero", 64'({wb_rd, wb_data}), 64'd0);
    chk("rstwb_malu_zero", 64'({malu_uop, malu_pw, malu_rs1}), 64'd0);
    resetn = 1'b1;
    wb_ready = 1'b1;
    step();
    chk("rstwb_no_hi_beat", 64'(wb_valid), 64'd0);
    // Single-beat mul with hi=1 after reset
    issue(4'd6, 3'd0, 1'b1, 1'b0, 32'h9, 32'h9, 32'h0, 5'd3);
    chk("post_rst_uop", 64'(malu_uop), 64'h0040);
    malu_ready = 1'b1; malu_result = 64'h0000_0011_0000_0022;
    sb.push_back('{rd: 5'd3, data: 32'h0000_0011});
    step();
    malu_ready = 1'b0;
    step();
    wb_ready = 1'b0;
    chk("post_rst_flush", 64'(malu_flush), 64'd1);
    step();
    chk("post_rst_idle", 64'(req_ready), 64'd1);

    step();
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xc_malu_issue.md
# xc_malu_issue

Issue and writeback sequencer for the XCrypto multi-cycle ALU. Accepts one decoded MALU instruction at a time from the pipeline and drives the ALU's operand, uop, pack-width, valid and flush inputs. It holds valid until the ALU signals ready, then returns the 64-bit result to the register file as one or two 32-bit writeback beats. Finally it flushes the ALU back to its idle state.

## Interface
- MAX_CYCLES, 72, RUN-state cycle limit before a timeout abort (range 2..127).
- clock  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- req_valid  in  1  instruction request valid.
- req_ready  out  1  sequencer can accept; high only in IDLE.
- req_op  in  4  uop code: 0 div, 1 divu, 2 rem, 3 remu, 4 mul, 5 mulu, 6 mulsu, 7 clmul, 8 pmul, 9 pclmul, 10 madd, 11 msub, 12 macc, 13 mmul; 14–15 illegal.
- req_pw  in  3  pack width: 0→32, 1→16, 2→8, 3→4, 4→2; 5–7 treated as 32.
- req_hi  in  1  single-beat writeback uses result[63:32] instead of result[31:0].
- req_wide  in  1  two-beat writeback of the full 64-bit result.
- req_rs1, req_rs2, req_rs3  in  32 each  source operands.
- req_rd  in  5  destination register.
- kill  in  1  pipeline cancel of the in-flight instruction.
- malu_rs1, malu_rs2, malu_rs3  out  32 each  registered operands to the ALU.
- malu_uop  out  14  one-hot uop; bit i corresponds to req_op value i.
- malu_pw  out  5  one-hot {pw_2, pw_4, pw_8, pw_16, pw_32}.
- malu_valid  out  1  ALU inputs valid.
- malu_flush  out  1  ALU state flush.
- malu_result  in  64  ALU result.
- malu_ready  in  1  ALU result ready.
- wb_valid  out  1  writeback beat valid.
- wb_ready  in  1  register file accepts the beat.
- wb_rd  out  5  writeback register.
- wb_data  out  32  writeback data.
- err_illegal  out  1  one-cycle pulse when an illegal req_op is accepted.
- err_timeout  out  1  one-cycle pulse when the RUN-state cycle limit is hit.

## Operation
- The FSM has five states: IDLE, RUN, WB_LO, WB_HI, FLUSH. All state is registered and outputs decode from state, so there are no combinational input-to-output paths except the ones listed below.
- **IDLE**
  - req_ready=1.
  - On req_valid with a legal op: latch operands, uop, pw, hi, wide and rd; clear the cycle counter; go to RUN.
  - On req_valid with an illegal op: pulse err_illegal next cycle and stay in IDLE. malu_valid is never raised.
- **RUN**
  - malu_valid=1. malu_uop, malu_pw and malu_rs* hold the latched values and stay stable for the whole state.
  - The 7-bit counter increments every cycle.
  - malu_ready=1: capture malu_result into a 64-bit result register and go to WB_LO.
  - Counter reaches MAX_CYCLES-1 without malu_ready: pulse err_timeout and go to FLUSH.
- **WB_LO**
  - wb_valid=1.
  - If wide: wb_rd={rd[4:1],0}, wb_data=res[31:0].
  - Otherwise: wb_rd=rd, wb_data=hi?res[63:32]:res[31:0].
  - On wb_ready: go to WB_HI if wide, else to FLUSH.
- **WB_HI**
  - wb_valid=1, wb_rd={rd[4:1],1}, wb_data=res[63:32].
  - On wb_ready: go to FLUSH.
- **FLUSH**
  - malu_flush=1, malu_valid=0, for exactly one cycle.
  - Then go to IDLE.
- **Kill and simultaneous events**
  - kill in RUN, WB_LO or WB_HI goes to FLUSH; pending beats are discarded. A beat already accepted is not retracted.
  - kill is ignored in IDLE and FLUSH.
  - kill wins over a simultaneous malu_ready or wb_ready.
  - Timeout and malu_ready in the same cycle: ready wins, no error.
- **Outside RUN:** malu_uop, malu_pw and malu_rs* hold their last values; only malu_valid gates them.
- **Reset**
  - A resetn=0 clock edge forces IDLE from any state, including mid-RUN and mid-WB.
  - Reset values: req_ready=1; malu_valid, malu_flush, wb_valid, err_* = 0; malu_uop, malu_pw, malu_rs*, wb_rd, wb_data, result register = 0.
  - The ALU is reset by its own resetn, so no flush is issued on reset.

## Timing
- Request accepted at edge N → malu_valid high from cycle N+1.
- malu_ready seen in cycle k → wb_valid high from cycle k+1.
- Minimum accept-to-wb_valid latency is 2 cycles, when malu_ready is high in the first RUN cycle.
- wb_rd and wb_data stay stable while wb_valid=1 and wb_ready=0.
- The FLUSH cycle always follows the last accepted beat, kill or timeout. req_ready rises the cycle after FLUSH.
- Minimum occupancy:
  - Single-beat op: 4 cycles (RUN, WB_LO, FLUSH, IDLE).
  - Wide op: 5 cycles.
- err_illegal and err_timeout are single-cycle pulses, registered.

## Test plan
- **Single-beat mul:** req_op=4, rs1=3, rs2=5, rd=7, hi=0. ALU model raises ready after 4 RUN cycles with result 64'h0000_0000_0000_000F → one beat rd=7 data=0000000F, then one malu_flush cycle, then req_ready=1.
- **Wide madd with backpressure:** req_op=10, wide=1, rd=9, result 64'h12345678_9ABCDEF0, wb_ready low 3 cycles per beat → beat rd=8 data=9ABCDEF0, then beat rd=9 data=12345678. Data stays stable while stalled.
- **Kill during RUN:** kill asserted in the 3rd RUN cycle, simultaneous with malu_ready → no wb_valid, malu_flush pulse next cycle, back to IDLE.
- **Timeout:** MAX_CYCLES=8, malu_ready never asserted → err_timeout pulse after 8 RUN cycles, one flush cycle, no writeback.
- **Illegal op:** req_op=15 → err_illegal pulse, malu_valid stays 0, req_ready stays 1.
- **Reset mid-writeback:** resetn low during WB_HI → all outputs at reset values next cycle, the hi beat is never issued, a new request is accepted after resetn rises.
